// File: rtl/pattern_generator_seq_ctrl.sv
// Launch sequencer for the pattern generator cfg wrapper: load seed, optional
// self-seed, seed-good check with retries, then run; registered cfg/status outputs.
module pattern_generator_seq_ctrl #(
  parameter int PattLength    = 32,
  parameter int PRBSLength    = 31,
  parameter int LoadCycles    = 4,
  parameter int SeedCycles    = 64,
  parameter int TimeoutCycles = 1024,
  parameter int GoodHold      = 4,
  parameter int MaxRetries    = 3,
  localparam int SeedLength   = (PattLength > PRBSLength) ? PattLength : PRBSLength,
  localparam int CfgBits      = SeedLength + 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode_pattern,
  input  logic                  mode_self_seed,
  input  logic                  out_invert,
  input  logic [SeedLength-1:0] seed_value,
  input  logic                  prbs_seed_good,
  output logic [CfgBits-1:0]    cfg,
  output logic                  busy,
  output logic                  running,
  output logic                  error,
  output logic [1:0]            retry_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEED,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  localparam int CntMax0 = (LoadCycles > SeedCycles) ? LoadCycles : SeedCycles;
  localparam int CntMax  = (CntMax0 > TimeoutCycles) ? CntMax0 : TimeoutCycles;
  localparam int CntW    = $clog2(CntMax + 1);
  localparam int GoodW   = $clog2(GoodHold + 1);

  localparam logic [CntW-1:0]  LoadLast    = CntW'(LoadCycles - 1);
  localparam logic [CntW-1:0]  SeedLast    = CntW'(SeedCycles - 1);
  localparam logic [CntW-1:0]  TimeoutLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0]  CntSat      = CntW'(CntMax);
  localparam logic [GoodW-1:0] GoodLast    = GoodW'(GoodHold - 1);
  localparam logic [1:0]       RetryMax    = 2'(MaxRetries);

  state_t                state_q, state_d;
  logic [CntW-1:0]       cyc_q, cyc_d;
  logic [GoodW-1:0]      good_cnt_q, good_cnt_d;
  logic [1:0]            retry_q, retry_d;
  logic                  pat_q, pat_d;
  logic                  self_q, self_d;
  logic                  inv_q, inv_d;
  logic [SeedLength-1:0] seed_q, seed_d;

  logic [CfgBits-1:0]    cfg_q, cfg_d;
  logic                  busy_q, busy_d;
  logic                  running_q, running_d;
  logic                  error_q, error_d;

  logic                  self_launch;
  logic                  lost;

  assign self_launch = self_q & ~pat_q;

  always_comb begin
    state_d    = state_q;
    cyc_d      = (cyc_q == CntSat) ? cyc_q : cyc_q + CntW'(1);
    good_cnt_d = good_cnt_q;
    retry_d    = retry_q;
    pat_d      = pat_q;
    self_d     = self_q;
    inv_d      = inv_q;
    seed_d     = seed_q;
    lost       = 1'b0;

    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          pat_d   = mode_pattern;
          self_d  = mode_self_seed;
          inv_d   = out_invert;
          seed_d  = seed_value;
          retry_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cyc_q == LoadLast) begin
          state_d = self_launch ? S_SEED : S_RUN;
        end
      end
      S_SEED: begin
        if (cyc_q == SeedLast) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // lock wins over a timeout landing on the same cycle
        if (prbs_seed_good) begin
          if (good_cnt_q == GoodLast) begin
            state_d = S_RUN;
          end else begin
            good_cnt_d = good_cnt_q + GoodW'(1);
          end
        end else begin
          good_cnt_d = '0;
        end
        if (state_d == S_CHECK && cyc_q == TimeoutLast) begin
          lost = 1'b1;
        end
      end
      S_RUN: begin
        if (self_launch) begin
          if (!prbs_seed_good) begin
            if (good_cnt_q == GoodLast) begin
              lost = 1'b1;
            end else begin
              good_cnt_d = good_cnt_q + GoodW'(1);
            end
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (lost) begin
      if (retry_q < RetryMax) begin
        retry_d = retry_q + 2'd1;
        state_d = S_LOAD;
      end else begin
        state_d = S_ERROR;
      end
    end

    // stop overrides everything, including a start in the same cycle
    if (stop) begin
      state_d = S_IDLE;
      retry_d = retry_q;
      pat_d   = pat_q;
      self_d  = self_q;
      inv_d   = inv_q;
      seed_d  = seed_q;
    end

    if (state_d != state_q) begin
      cyc_d      = '0;
      good_cnt_d = '0;
    end
  end

  // Outputs are decoded from the current state and registered, so they trail it by one cycle.
  always_comb begin
    logic run_bit;
    logic seed_bit;
    run_bit   = (state_q == S_SEED) || (state_q == S_CHECK) || (state_q == S_RUN);
    seed_bit  = (state_q == S_SEED);
    cfg_d     = {inv_q, seed_bit, run_bit, pat_q, seed_q};
    busy_d    = (state_q == S_LOAD) || (state_q == S_SEED) || (state_q == S_CHECK);
    running_d = (state_q == S_RUN);
    error_d   = (state_q == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      good_cnt_q <= '0;
      retry_q    <= '0;
      pat_q      <= 1'b0;
      self_q     <= 1'b0;
      inv_q      <= 1'b0;
      seed_q     <= '0;
      cfg_q      <= '0;
      busy_q     <= 1'b0;
      running_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      good_cnt_q <= good_cnt_d;
      retry_q    <= retry_d;
      pat_q      <= pat_d;
      self_q     <= self_d;
      inv_q      <= inv_d;
      seed_q     <= seed_d;
      cfg_q      <= cfg_d;
      busy_q     <= busy_d;
      running_q  <= running_d;
      error_q    <= error_d;
    end
  end

  assign cfg         = cfg_q;
  assign busy        = busy_q;
  assign running     = running_q;
  assign error       = error_q;
  assign retry_count = retry_q;

endmodule
